// File: rtl/dff_arb_pkg.sv
// Shared definitions for the shared D-register arbiter.
//   ST_IDLE / ST_HOLD : FSM state encodings
//   clog2_min1(n)     : index width that is never zero (1 for n <= 1)
package dff_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Width of an index able to address n items; a single item still gets one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
// Searches req starting at (last+1) mod N upward with wrap-around and
// returns the first set bit.
//   req        in   N      request vector
//   last       in   OWN_W  index of the previous winner
//   gnt_onehot out  N      one-hot winner (all zero when nothing requests)
//   gnt_idx    out  OWN_W  winner index (0 when nothing requests)
//   any        out  1      at least one request present
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned OWN_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [OWN_W-1:0] last,
    output logic [N-1:0]     gnt_onehot,
    output logic [OWN_W-1:0] gnt_idx,
    output logic             any
);

    logic        hi_any;
    logic        lo_any;
    int unsigned hi_idx;
    int unsigned lo_idx;
    int unsigned pick;

    // Lowest requester above last wins; otherwise wrap to the lowest at or below last.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = 32'd0;
        lo_idx = 32'd0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (32'(i) > 32'(last)) begin
                    hi_any = 1'b1;
                    hi_idx = 32'(i);
                end else begin
                    lo_any = 1'b1;
                    lo_idx = 32'(i);
                end
            end
        end
    end

    // Final selection and one-hot expansion.
    always_comb begin
        any        = hi_any | lo_any;
        pick       = hi_any ? hi_idx : lo_idx;
        gnt_idx    = OWN_W'(pick);
        gnt_onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            gnt_onehot[i] = any && (pick == 32'(i));
        end
    end

endmodule

// File: rtl/dff_share_arbiter.sv
// One DATA_W-bit D-register (true + complement) shared by NUM_REQ writers.
// A round-robin arbiter grants one writer per transfer; after each write the
// register is locked for HOLD_CYCLES cycles before the next grant.
//   clk        in   1               rising-edge clock
//   rst        in   1               asynchronous active-high reset
//   req_valid  in   NUM_REQ         writer i requests a write
//   req_data   in   NUM_REQ*DATA_W  writer i data at [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ         one-hot grant, combinational from req_valid
//   q          out  DATA_W          stored value
//   q_n        out  DATA_W          bitwise complement of q
//   owner      out  OWN_W           writer of the current q
//   busy       out  1               register locked (HOLD)
//   upd        out  1               pulse in the cycle after a write
module dff_share_arbiter
    import dff_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned DATA_W      = 8,
    parameter  int unsigned HOLD_CYCLES = 2,
    localparam int unsigned OWN_W       = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         q,
    output logic [DATA_W-1:0]         q_n,
    output logic [OWN_W-1:0]          owner,
    output logic                      busy,
    output logic                      upd
);

    localparam int unsigned CNT_W = clog2_min1(HOLD_CYCLES);

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   hold_cnt_nxt;
    logic [OWN_W-1:0]   last;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [OWN_W-1:0]   gnt_idx;
    logic               any;
    logic               load;
    logic [DATA_W-1:0]  win_data;

    // Round-robin winner among the current requests.
    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req        (req_valid),
        .last       (last),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // Data mux driven by the one-hot grant.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_onehot[i]) begin
                win_data = win_data | req_data[i*int'(DATA_W) +: DATA_W];
            end
        end
    end

    // Next-state and grant logic; grants only in IDLE.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        req_ready    = '0;
        load         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    req_ready    = gnt_onehot;
                    load         = 1'b1;
                    hold_cnt_nxt = CNT_W'(HOLD_CYCLES - 32'd1);
                    state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Shared register, ownership and status outputs.
    // last resets to NUM_REQ-1 so that writer 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            q_n   <= '1;
            owner <= '0;
            last  <= OWN_W'(NUM_REQ - 32'd1);
            busy  <= 1'b0;
            upd   <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_HOLD);
            upd  <= load;
            if (load) begin
                q     <= win_data;
                q_n   <= ~win_data;
                owner <= gnt_idx;
                last  <= gnt_idx;
            end
        end
    end

endmodule
